// File: rtl/me_result_collector_if.sv
// Result stream from the collector FIFO toward the frame-level MV writer.
interface me_result_collector_if;
  logic        valid;
  logic        ready;
  logic [39:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/me_result_collector.sv
// Captures per-block SAD/MV results, tags them with raster coordinates, buffers
// them in a first-word-fall-through FIFO and keeps a saturating per-frame SAD total.
module me_result_collector #(
  parameter int unsigned BLKS_X     = 480,
  parameter int unsigned BLKS_Y     = 270,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_start_i,
  input  logic                  res_valid_i,
  input  logic [13:0]           sad_min_i,
  input  logic [3:0]            motion_vec_x_min_i,
  input  logic [3:0]            motion_vec_y_min_i,
  input  logic                  ovf_clr_i,
  output logic                  overflow_o,
  output logic                  frame_done_o,
  output logic [31:0]           frame_sad_o,
  me_result_collector_if.master out_if
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [8:0]  LastX = 9'(BLKS_X - 1);
  localparam logic [8:0]  LastY = 9'(BLKS_Y - 1);

  logic [8:0]      blk_x_q, blk_x_d, blk_y_q, blk_y_d;
  logic [31:0]     acc_q, acc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            fdone_q, fdone_d;
  logic [31:0]     fsad_q, fsad_d;
  logic [39:0]     mem_q [FIFO_DEPTH];

  logic [8:0]  cur_x, cur_y;
  logic [31:0] acc_base, acc_sat;
  logic [32:0] acc_sum;
  logic        last_blk, push_ok, pop, not_empty;
  logic [39:0] pkt;

  // frame_start re-bases the coordinates and sum before a same-cycle capture.
  always_comb begin
    cur_x     = frame_start_i ? 9'd0 : blk_x_q;
    cur_y     = frame_start_i ? 9'd0 : blk_y_q;
    acc_base  = frame_start_i ? 32'd0 : acc_q;
    last_blk  = (cur_x == LastX) && (cur_y == LastY);
    acc_sum   = {1'b0, acc_base} + 33'(sad_min_i);
    acc_sat   = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    not_empty = (cnt_q != '0);
    // Acceptance depends only on current occupancy, not on a same-cycle pop.
    push_ok   = res_valid_i && (cnt_q < CntW'(FIFO_DEPTH));
    pop       = not_empty && out_if.ready;
    pkt       = {cur_y, cur_x, motion_vec_y_min_i, motion_vec_x_min_i, sad_min_i};
  end

  // Next-state for coordinates, accumulator, frame completion and overflow.
  always_comb begin
    blk_x_d = blk_x_q;
    blk_y_d = blk_y_q;
    acc_d   = acc_q;
    fdone_d = 1'b0;
    fsad_d  = fsad_q;
    if (res_valid_i) begin
      if (last_blk) begin
        blk_x_d = 9'd0;
        blk_y_d = 9'd0;
        acc_d   = 32'd0;
        fdone_d = 1'b1;
        fsad_d  = acc_sat;
      end else if (cur_x == LastX) begin
        blk_x_d = 9'd0;
        blk_y_d = cur_y + 9'd1;
        acc_d   = acc_sat;
      end else begin
        blk_x_d = cur_x + 9'd1;
        blk_y_d = cur_y;
        acc_d   = acc_sat;
      end
    end else if (frame_start_i) begin
      blk_x_d = 9'd0;
      blk_y_d = 9'd0;
      acc_d   = 32'd0;
    end

    // A dropping push wins over a same-cycle clear.
    ovf_d = ovf_q;
    if (res_valid_i && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_x_q  <= '0;
      blk_y_q  <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fdone_q  <= 1'b0;
      fsad_q   <= '0;
    end else begin
      blk_x_q  <= blk_x_d;
      blk_y_q  <= blk_y_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fdone_q  <= fdone_d;
      fsad_q   <= fsad_d;
    end
  end

  // Storage needs no reset: stale entries are invisible once occupancy is zero.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= pkt;
    end
  end

  // Head of FIFO is presented directly; zero when empty.
  always_comb begin
    out_if.valid = not_empty;
    out_if.data  = not_empty ? mem_q[rd_ptr_q] : 40'd0;
    overflow_o   = ovf_q;
    frame_done_o = fdone_q;
    frame_sad_o  = fsad_q;
  end

endmodule

// File: tb/tb_me_result_collector.sv
// Directed and randomized bench for me_result_collector against a queue-based model.
module tb_me_result_collector;

  localparam int unsigned BX = 4;
  localparam int unsigned BY = 2;
  localparam int unsigned D  = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        frame_start, res_valid, ovf_clr;
  logic [13:0] sad;
  logic [3:0]  mvx, mvy;
  logic        overflow, frame_done;
  logic [31:0] frame_sad;

  me_result_collector_if u_if ();

  me_result_collector #(
    .BLKS_X    (BX),
    .BLKS_Y    (BY),
    .FIFO_DEPTH(D)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .frame_start_i     (frame_start),
    .res_valid_i       (res_valid),
    .sad_min_i         (sad),
    .motion_vec_x_min_i(mvx),
    .motion_vec_y_min_i(mvy),
    .ovf_clr_i         (ovf_clr),
    .overflow_o        (overflow),
    .frame_done_o      (frame_done),
    .frame_sad_o       (frame_sad),
    .out_if            (u_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: block index within the frame, queue of packets, plain sums.
  logic [39:0] mq[$];
  int unsigned nblk;
  longint      macc;
  bit          movf, mfd;
  logic [31:0] mfsad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    nblk  = 0;
    macc  = 0;
    movf  = 0;
    mfd   = 0;
    mfsad = 0;
  endtask

  task automatic compare_outputs();
    check("out_valid", u_if.valid, mq.size() > 0);
    check("out_data", u_if.data, (mq.size() > 0) ? mq[0] : 40'd0);
    check("overflow", overflow, movf);
    check("frame_done", frame_done, mfd);
    check("frame_sad", frame_sad, mfsad);
  endtask

  // One clock: compare, drive at the falling edge, predict the next rising edge.
  task automatic step(input bit rv, input logic [13:0] s, input logic [3:0] mx,
                      input logic [3:0] my, input bit fs, input bit rdy, input bit clr);
    bit          accept, pp;
    logic [39:0] pkt;
    compare_outputs();
    res_valid   = rv;
    sad         = s;
    mvx         = mx;
    mvy         = my;
    frame_start = fs;
    u_if.ready  = rdy;
    ovf_clr     = clr;
    accept = mq.size() < D;
    pp     = (mq.size() > 0) && rdy;
    if (fs) begin
      nblk = 0;
      macc = 0;
    end
    mfd = 0;
    pkt = '0;
    if (rv) begin
      pkt  = {9'(nblk / BX), 9'(nblk % BX), my, mx, s};
      macc = macc + longint'(s);
      if (macc > 64'hFFFF_FFFF) macc = 64'hFFFF_FFFF;
      nblk++;
      if (nblk == BX * BY) begin
        mfd   = 1;
        mfsad = 32'(macc);
        macc  = 0;
        nblk  = 0;
      end
    end
    if (rv && !accept) movf = 1;
    else if (clr) movf = 0;
    if (pp) void'(mq.pop_front());
    if (rv && accept) mq.push_back(pkt);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, 14'd0, 4'd0, 4'd0, 0, rdy, 0);
  endtask

  initial begin
    int sum;
    logic [13:0] s;
    rst_ni = 1'b0;
    frame_start = 0; res_valid = 0; ovf_clr = 0; sad = 0; mvx = 0; mvy = 0;
    u_if.ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_outputs();
    rst_ni = 1'b1;

    // Basic flow after reset.
    step(1, 14'd100, 4'd3, 4'd5, 0, 1, 0);
    check("basic_pkt", u_if.data, {9'd0, 9'd0, 4'd5, 4'd3, 14'd100});
    idle(1);
    check("basic_popped", u_if.valid, 1'b0);

    // Raster order and frame end.
    step(0, 14'd0, 4'd0, 4'd0, 1, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 14'(i), 4'(i), 4'(15 - i), 0, 1, 0);
    end
    check("frame_done_pulse", frame_done, 1'b1);
    check("frame_sad_36", frame_sad, 32'd36);
    step(1, 14'd9, 4'd0, 4'd0, 0, 1, 0);
    check("ninth_tag", u_if.data, {18'd0, 8'd0, 14'd9});
    check("frame_done_once", frame_done, 1'b0);
    idle(1);

    // Backpressure and overflow.
    for (int i = 0; i < 5; i++) begin
      step(1, 14'(10 + i), 4'd1, 4'd2, 0, 0, 0);
    end
    check("overflow_set", overflow, 1'b1);
    idle(0);
    idle(0);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", u_if.valid, 1'b1);
      check("drain_order", u_if.data[13:0], 14'(10 + i));
      idle(1);
    end
    check("drain_empty", u_if.valid, 1'b0);
    step(0, 14'd0, 4'd0, 4'd0, 0, 1, 1);
    check("overflow_clr", overflow, 1'b0);

    // frame_start colliding with res_valid aborts the partial frame.
    step(0, 14'd0, 4'd0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 14'(20 + i), 4'd0, 4'd0, 0, 1, 0);
    step(1, 14'd7, 4'd4, 4'd6, 1, 1, 0);
    check("collide_tag", u_if.data, {18'd0, 4'd6, 4'd4, 14'd7});
    sum = 7;
    for (int i = 0; i < 7; i++) begin
      check("no_abort_done", frame_done, 1'b0);
      s = 14'($urandom_range(0, 16383));
      sum += int'(s);
      step(1, s, 4'd0, 4'd0, 0, 1, 0);
    end
    check("collide_done", frame_done, 1'b1);
    check("collide_sad", frame_sad, 32'(sum));

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1, 14'(30 + i), 4'd0, 4'd0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_valid", u_if.valid, 1'b0);
    check("rst_data", u_if.data, 40'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_sad", frame_sad, 32'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    step(1, 14'd55, 4'd9, 4'd8, 0, 1, 0);
    check("rst_tag", u_if.data, {18'd0, 4'd8, 4'd9, 14'd55});
    idle(1);

    // Saturation of the frame total with a preloaded accumulator.
    step(0, 14'd0, 4'd0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 14'd16383, 4'd0, 4'd0, 0, 1, 0);
    force dut.acc_q = 32'hFFFF_F000;
    #1 release dut.acc_q;
    macc = 64'hFFFF_F000;
    step(1, 14'd16383, 4'd0, 4'd0, 0, 1, 0);
    check("sat_sad", frame_sad, 32'hFFFF_FFFF);
    idle(1);

    // Randomized traffic.
    step(0, 14'd0, 4'd0, 4'd0, 1, 1, 1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, 14'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 8; i++) idle(1);
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
